// File: rtl/prbs_derandomizer_if.sv
// 1-bit valid/ready stream bundle around the PRBS derandomizer: the input side
// (randomized bits in) and the output side (derandomized bits plus block-last marker).
interface prbs_derandomizer_if;
  logic in_valid;
  logic in_data;
  logic in_ready;
  logic out_valid;
  logic out_data;
  logic out_last;
  logic out_ready;

  // master: the surrounding datapath (upstream source and downstream sink)
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // slave: the derandomizer itself
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/prbs_derandomizer.sv
// Receive-side 802.16 PRBS derandomizer (1 + x^14 + x^15), re-seeded at every
// BLOCK_LEN-bit block boundary, with a single registered output stage.
module prbs_derandomizer #(
  parameter int          BLOCK_LEN = 96,
  parameter logic [14:0] SEED      = 15'h3715
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  clear,
  prbs_derandomizer_if.slave    s
);

  localparam int            CW       = $clog2(BLOCK_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(BLOCK_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, LOAD} state_t;

  state_t        state, state_nxt;
  logic [14:0]   lfsr, lfsr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic out_valid_q, out_data_q, out_last_q;
  logic in_ready;
  logic accept;
  logic fb;
  logic is_last;

  // out_ready -> in_ready is deliberately combinational so the single output
  // register can refill in the same cycle it drains.
  assign in_ready = (state != LOAD) && !clear && (!out_valid_q || s.out_ready);
  assign accept   = s.in_valid && in_ready;
  assign fb       = lfsr[13] ^ lfsr[14];
  assign is_last  = (state == RUN) && (cnt == LAST_CNT);

  always_ff @(posedge clk or negedge resetN) begin
    // NOTE: sequential state uses non-blocking assignments only; blocking here
    // would let later statements see this cycle's new values and break ordering.
    if (!resetN) begin
      state <= IDLE;
      lfsr  <= SEED;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      lfsr  <= lfsr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt = state;
    lfsr_nxt  = lfsr;
    cnt_nxt   = cnt;

    if (clear) begin
      state_nxt = LOAD;
      lfsr_nxt  = SEED;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            lfsr_nxt  = {lfsr[13:0], fb};
            cnt_nxt   = CW'(1);
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (accept) begin
            lfsr_nxt = {lfsr[13:0], fb};
            if (is_last) begin
              state_nxt = LOAD;
            end else begin
              cnt_nxt = cnt + CW'(1);
            end
          end
        end
        LOAD: begin
          lfsr_nxt  = SEED;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
          lfsr_nxt  = SEED;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output stage: a held bit survives clear and drains normally; only reset drops it.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= s.in_data ^ fb;
      out_last_q  <= is_last;
    end else if (s.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign s.in_ready  = in_ready;
  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;
  assign s.out_last  = out_last_q;

endmodule

// File: tb/tb_prbs_derandomizer.sv
// Self-checking bench for prbs_derandomizer: reset vector table, directed block,
// clear, backpressure and reset sequences, and random loopback via a golden randomizer.
module tb_prbs_derandomizer;

  localparam int BL = 96;

  logic clk = 1'b0;
  logic resetN;
  logic clear;

  always #5 clk = ~clk;

  prbs_derandomizer_if bus ();

  prbs_derandomizer #(.BLOCK_LEN(BL), .SEED(15'h3715)) dut (
    .clk    (clk),
    .resetN (resetN),
    .clear  (clear),
    .s      (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit ks[BL];
  bit exp_d[$], exp_l[$];
  bit obs_d[$], obs_l[$];
  int pos = 0;
  bit acc;

  typedef struct {
    bit iv, d, ordy;
    bit e_rdy, e_ov, e_od, e_ol;
  } vec_t;

  // Keystream from the recurrence x[n+15] = x[n] ^ x[n+1], where x[0..14] are the
  // seed bits read from bit 14 down to bit 0.
  task automatic build_ks();
    logic [14:0] seed = 15'h3715;
    bit x[BL + 15];
    for (int i = 0; i < 15; i++) x[i] = seed[14 - i];
    for (int n = 0; n < BL; n++) begin
      x[n + 15] = x[n] ^ x[n + 1];
      ks[n]     = x[n + 15];
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle, entered and left at a falling edge; samples 1 time unit after driving.
  task automatic step(input bit iv, input bit d, input bit ordy, input bit clr,
                      output bit rdy, output bit ov, output bit od, output bit ol);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    clear         = clr;
    #1;
    rdy = bus.in_ready;
    ov  = bus.out_valid;
    od  = bus.out_data;
    ol  = bus.out_last;
    if (ov && ordy) begin
      if (exp_d.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        check("sb_data", od, exp_d.pop_front());
        check("sb_last", ol, exp_l.pop_front());
      end
      obs_d.push_back(od);
      obs_l.push_back(ol);
    end
    if (clr) begin
      check("clear_blocks_ready", rdy, 0);
      pos = 0;
    end
    acc = iv && rdy;
    if (acc) begin
      exp_d.push_back(d ^ ks[pos]);
      exp_l.push_back(pos == BL - 1);
      pos = (pos == BL - 1) ? 0 : pos + 1;
    end
    @(negedge clk);
  endtask

  task automatic send(input bit bits[$], input int vp, input int rp);
    bit rdy, ov, od, ol;
    int i = 0;
    int cyc = 0;
    int budget = bits.size() * 20 + 100;
    while (i < bits.size() && cyc < budget) begin
      step($urandom_range(99) < vp, bits[i], $urandom_range(99) < rp, 1'b0, rdy, ov, od, ol);
      if (acc) i++;
      cyc++;
    end
    if (i < bits.size()) check("send_timeout", i, bits.size());
  endtask

  task automatic drain();
    bit rdy, ov, od, ol;
    int cyc = 0;
    do begin
      step(0, 0, 1, 0, rdy, ov, od, ol);
      cyc++;
    end while ((exp_d.size() != 0 || bus.out_valid) && cyc < 200);
    check("drain_empty", exp_d.size(), 0);
  endtask

  task automatic resync();
    bit rdy, ov, od, ol;
    step(0, 0, 1, 1, rdy, ov, od, ol);
    step(0, 0, 1, 0, rdy, ov, od, ol);
    check("load_ready_low", rdy, 0);
    drain();
    obs_d.delete();
    obs_l.delete();
  endtask

  function automatic bit [3:0] first4();
    return {obs_d[0], obs_d[1], obs_d[2], obs_d[3]};
  endfunction

  function automatic int count_last();
    int c = 0;
    foreach (obs_l[i]) c += obs_l[i];
    return c;
  endfunction

  initial begin
    bit rdy, ov, od, ol;
    bit zeros[$];
    bit bits[$];
    bit orig[$];
    vec_t vecs[6];
    int zero_rdy, cyc, mism;
    bit held;

    build_ks();
    bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 1; clear = 0;
    resetN = 0;
    repeat (2) @(negedge clk);
    resetN = 1;

    // Reset state, then four zero bits -> 1,0,1,1 one cycle after each accept.
    vecs[0] = '{iv:1, d:0, ordy:1, e_rdy:1, e_ov:0, e_od:0, e_ol:0};
    vecs[1] = '{iv:1, d:0, ordy:1, e_rdy:1, e_ov:1, e_od:1, e_ol:0};
    vecs[2] = '{iv:1, d:0, ordy:1, e_rdy:1, e_ov:1, e_od:0, e_ol:0};
    vecs[3] = '{iv:1, d:0, ordy:1, e_rdy:1, e_ov:1, e_od:1, e_ol:0};
    vecs[4] = '{iv:0, d:0, ordy:1, e_rdy:1, e_ov:1, e_od:1, e_ol:0};
    vecs[5] = '{iv:0, d:0, ordy:1, e_rdy:1, e_ov:0, e_od:1, e_ol:0};
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].iv, vecs[i].d, vecs[i].ordy, 1'b0, rdy, ov, od, ol);
      check($sformatf("vec%0d_in_ready", i), rdy, vecs[i].e_rdy);
      check($sformatf("vec%0d_out_valid", i), ov, vecs[i].e_ov);
      if (vecs[i].e_ov) begin
        check($sformatf("vec%0d_out_data", i), od, vecs[i].e_od);
        check($sformatf("vec%0d_out_last", i), ol, vecs[i].e_ol);
      end
    end

    // Two back-to-back all-zero blocks: identical keystreams, one bubble between.
    resync();
    zero_rdy = 0; cyc = 0;
    for (int n = 0; n < 2 * BL && cyc < 500; ) begin
      step(1, 0, 1, 0, rdy, ov, od, ol);
      if (!rdy) zero_rdy++;
      if (acc) n++;
      cyc++;
    end
    check("two_blocks_cycles", cyc, 2 * BL + 1);
    check("two_blocks_bubbles", zero_rdy, 1);
    step(0, 0, 1, 0, rdy, ov, od, ol);
    check("post_block_load", rdy, 0);
    step(0, 0, 1, 0, rdy, ov, od, ol);
    check("post_block_idle", rdy, 1);
    drain();
    check("two_blocks_count", obs_d.size(), 2 * BL);
    mism = 0;
    for (int i = 0; i < BL; i++) if (obs_d[i] != obs_d[i + BL]) mism++;
    check("blocks_identical", mism, 0);
    check("block_first4", first4(), 4'b1011);
    check("last_bit96", obs_l[BL - 1], 1);
    check("last_bit192", obs_l[2 * BL - 1], 1);
    check("last_count", count_last(), 2);

    // Loopback through a golden randomizer, random valid/ready.
    resync();
    orig.delete(); bits.delete();
    for (int i = 0; i < 3 * BL; i++) begin
      orig.push_back($urandom_range(1));
      bits.push_back(orig[i] ^ ks[i % BL]);
    end
    send(bits, 70, 70);
    drain();
    check("loopback_count", obs_d.size(), 3 * BL);
    mism = 0;
    foreach (obs_d[i]) if (obs_d[i] != orig[i]) mism++;
    check("loopback_bits", mism, 0);
    check("loopback_lasts", count_last(), 3);

    // Backpressure for 5 cycles mid-block.
    resync();
    zeros.delete();
    repeat (20) zeros.push_back(0);
    send(zeros, 100, 100);
    step(1, 0, 0, 0, rdy, ov, od, ol);
    held = od;
    check("bp_valid", ov, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, rdy, ov, od, ol);
      check("bp_in_ready", rdy, 0);
      check("bp_hold_valid", ov, 1);
      check("bp_hold_data", od, held);
    end
    zeros.delete();
    repeat (BL - 20) zeros.push_back(0);
    send(zeros, 100, 100);
    drain();
    check("bp_count", obs_d.size(), BL);
    check("bp_last", obs_l[BL - 1], 1);

    // Clear after bit 40, then a full zero block.
    resync();
    zeros.delete();
    repeat (40) zeros.push_back(0);
    send(zeros, 100, 100);
    step(1, 0, 1, 1, rdy, ov, od, ol);
    check("clear_out_valid_kept", ov, 1);
    obs_d.delete(); obs_l.delete();
    zeros.delete();
    repeat (BL) zeros.push_back(0);
    send(zeros, 100, 100);
    drain();
    check("clear_count", obs_d.size(), BL);
    check("clear_first4", first4(), 4'b1011);
    check("clear_last96", obs_l[BL - 1], 1);
    check("clear_last_count", count_last(), 1);

    // clear together with the 96th accept: clear wins, no out_last.
    resync();
    zeros.delete();
    repeat (BL - 1) zeros.push_back(0);
    send(zeros, 100, 100);
    step(1, 0, 1, 1, rdy, ov, od, ol);
    step(1, 0, 1, 0, rdy, ov, od, ol);
    check("clear96_load", rdy, 0);
    drain();
    check("clear96_count", obs_d.size(), BL - 1);
    check("clear96_no_last", count_last(), 0);

    // Reset mid-block with a held output bit.
    resync();
    zeros.delete();
    repeat (30) zeros.push_back(0);
    send(zeros, 100, 100);
    step(0, 0, 0, 0, rdy, ov, od, ol);
    check("pre_reset_valid", ov, 1);
    resetN = 0;
    #1;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_data", bus.out_data, 0);
    exp_d.delete(); exp_l.delete(); pos = 0;
    @(negedge clk);
    resetN = 1;
    obs_d.delete(); obs_l.delete();
    zeros.delete();
    repeat (4) zeros.push_back(0);
    send(zeros, 100, 100);
    drain();
    check("reset_first4", first4(), 4'b1011);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs_derandomizer.md
# prbs_derandomizer

Receive-side counterpart of the transmit PRBS randomizer: XORs each incoming bit with the 802.16 keystream (1 + x^14 + x^15) to recover the original data. It sits between the receive datapath upstream and the FEC decoder downstream. It re-seeds the LFSR at every BLOCK_LEN-bit block boundary, so it stays aligned with the transmitter's per-block seeding. Bits flow through a 1-bit valid/ready stream with a single registered output stage.

## Interface
- BLOCK_LEN, 96, bits per randomization block; must be ≥ 2.
- SEED, 15'h3715, LFSR seed; SEED[i] loads lfsr[i].
- clk  in  1  clock, rising edge.
- resetN  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort of the current block; re-seeds the LFSR.
- in_valid  in  1  in_data is valid.
- in_data  in  1  randomized bit.
- in_ready  out  1  block can accept a bit this cycle.
- out_valid  out  1  out_data is valid.
- out_data  out  1  derandomized bit.
- out_last  out  1  marks the BLOCK_LEN-th bit of a block; qualified by out_valid.
- out_ready  in  1  downstream accepts the bit this cycle.

## Operation
- LFSR lfsr[14:0]:
  - Feedback fb = lfsr[13] ^ lfsr[14].
  - On each accepted input bit: out bit = in_data ^ fb, then lfsr <= {lfsr[13:0], fb}.
- Counter cnt, width $clog2(BLOCK_LEN), counts accepted bits within the current block.
- FSM states:
  - IDLE: lfsr = SEED, cnt = 0, in_ready per the rule below. On accept, go to RUN.
  - RUN: on each accept, increment cnt. When the accepted bit is number BLOCK_LEN (cnt == BLOCK_LEN-1), set out_last on that bit and go to LOAD.
  - LOAD: in_ready = 0 for exactly one cycle. lfsr <= SEED, cnt <= 0. Then go to IDLE.
- Accept condition: in_valid && in_ready.
- in_ready = (state != LOAD) && (!out_valid || out_ready). This is a combinational path from out_ready to in_ready.
- Output register: loads out_data and out_last on accept. out_valid stays high until out_valid && out_ready; if a new accept happens in the same cycle, it refills with the new bit.
- clear = 1 in any state:
  - Next state is LOAD.
  - cnt zeroed.
  - A bit presented in the same cycle is not accepted (in_ready forced 0).
  - A bit already held in the output register is not dropped; it drains normally.
- No arithmetic overflow: cnt never exceeds BLOCK_LEN-1.

## Timing
- Reset values:
  - state = IDLE, lfsr = SEED, cnt = 0.
  - out_valid = 0, out_data = 0, out_last = 0.
  - in_ready = 1 once resetN is released, since the output register is empty.
- Latency: 1 cycle from accept to out_valid.
- Throughput:
  - 1 bit/cycle within a block.
  - 1-cycle bubble (LOAD) after each block, giving BLOCK_LEN bits per BLOCK_LEN+1 cycles.
- Backpressure: while out_valid = 1 and out_ready = 0, in_ready = 0. out_data and out_last hold stable.
- Reset asserted mid-block: all state returns to reset values immediately; the pending output bit is discarded.
- clear and the BLOCK_LEN-th accept in the same cycle: clear wins, the bit is not accepted, and the FSM goes to LOAD.

## Test plan
- Reset, then 4 zero bits with out_ready = 1 -> out_data = 1,0,1,1, each 1 cycle after its accept; out_last = 0.
- Two full 96-bit all-zero blocks streamed back to back -> identical keystreams; out_last high on bits 96 and 192; in_ready low exactly 1 cycle after each block.
- Loopback: random data through a golden randomizer into this block, 3 blocks -> output equals the original data bit-for-bit.
- out_ready held low for 5 cycles mid-block -> in_ready low, out_data stable, no bit lost or duplicated, keystream continues correctly.
- clear after bit 40, then 96 zero bits -> keystream restarts at 1,0,1,1; out_last on the 96th bit after clear.
- resetN pulsed low mid-block with out_valid = 1 -> out_valid = 0 immediately; the next block's output restarts at 1,0,1,1.
